acsi_dma_bridge: RTL and testbench
==================================

# acsi_dma_bridge

Byte/word bridge between the SD sector engine and the ST DMA 16-bit FIFO, sitting directly downstream of the ACSI target controller. It packs SD read bytes into big-endian FIFO words and unpacks FIFO words into SD write bytes. It tracks the remaining sector count and raises `data_next` / `dma_done` back to the ACSI controller. When no sector transfer is running, it also drains ACSI command-reply words into the same FIFO.

## Interface
- `SECTOR_BYTES`, default 512: bytes per sector; must be even, at most 512.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a transfer; honoured only in IDLE.
- `dir` in 1: sampled with `start`; 0 = read (SD→FIFO), 1 = write (FIFO→SD).
- `sector_count` in 8: sampled with `start`; number of sectors.
- `sd_rd_data` in 8: SD read byte.
- `sd_rd_strobe` in 1: `sd_rd_data` valid this cycle.
- `sd_rd_stall` out 1: SD engine must not strobe while high.
- `sd_wr_data` out 8: byte to SD.
- `sd_wr_valid` out 1: `sd_wr_data` valid.
- `sd_wr_ready` in 1: byte consumed when `sd_wr_valid && sd_wr_ready`.
- `fifo_wdata` out 16 / `fifo_wr` out 1 / `fifo_full` in 1: FIFO write port.
- `fifo_rdata` in 16 / `fifo_rd` out 1 / `fifo_empty` in 1: FIFO read port; data valid the cycle after `fifo_rd`.
- `reply_data` in 16 / `reply_req` in 1 / `reply_ack` out 1: ACSI reply words.
- `data_next` out 1: one-cycle pulse; sector done, more remain.
- `dma_done` out 1: one-cycle pulse; last sector done.
- `active` out 1: high in READ or WRITE.
- `sectors_left` out 8: remaining sector count.

## Operation
- States: IDLE, READ, WRITE. All outputs reset to 0. The state resets to IDLE, and the byte counter, word holding register, and sectors_left reset to 0.
- IDLE + `start`:
  - `sector_count == 0`: pulse `dma_done` the next cycle and remain in IDLE.
  - Otherwise: load sectors_left, clear the 9-bit byte counter, and go to READ (`dir = 0`) or WRITE (`dir = 1`).
  - `start` in READ/WRITE is ignored.
- READ:
  - Even byte (counter bit 0 = 0) latches into the high half; odd byte completes the word.
  - The completed word goes to a one-word holding register. `fifo_wr` is asserted with it whenever `!fifo_full`.
  - `sd_rd_stall` = holding register occupied && `fifo_full`.
  - A strobe while stalled is a protocol error; that byte is dropped.
- WRITE:
  - If the holding register is empty and `!fifo_empty`, pulse `fifo_rd`. The word is captured on the next cycle.
  - Present the high byte, then the low byte, on `sd_wr_data` with `sd_wr_valid` high.
  - Each handshake increments the byte counter. The holding register frees after the low byte.
- Sector end: the handshake that brings the byte counter to `SECTOR_BYTES`.
  - Clear the counter and decrement sectors_left.
  - If the new value is greater than 0: pulse `data_next` and stay in state.
  - Else: pulse `dma_done` and return to IDLE. In READ, return to IDLE only after the holding register has drained to the FIFO, so `dma_done` waits for the final `fifo_wr`.
- Reply path, IDLE only:
  - If `reply_req && !fifo_full && !start`: `fifo_wdata = reply_data`, `fifo_wr = 1`, `reply_ack = 1`, all in the same cycle.
  - `start` has priority over a pending reply in the same cycle.
  - Replies are never acked in READ/WRITE.
- Arithmetic: the byte counter is 9 bits wide. sectors_left is 8 bits wide and never decrements below 0.
- Reset mid-transfer aborts immediately:
  - No further `fifo_wr`, `fifo_rd`, or pulses.
  - A partial word is discarded.

## Timing
- READ: `fifo_wr` rises the cycle after the odd-byte strobe when the FIFO is not full. With the FIFO full, it rises the cycle after `fifo_full` falls.
- WRITE: the cycle of `fifo_rd` is N. The high byte is valid at N+2, and the low byte is valid on the cycle after the high-byte handshake.
- `data_next` / `dma_done` are asserted the cycle after the completing handshake, with the READ drain exception above. The pulse is exactly 1 cycle.
- `sd_rd_stall` is combinational from registered state and `fifo_full`.
- `reply_ack` is combinational with `fifo_wr`. Back-to-back reply words are accepted one per cycle.

## Test plan
- Read 2 sectors, FIFO never full, bytes 0x00..0xFF repeating:
  - FIFO receives 512 words, the first being 0x0001 then 0x0203.
  - `data_next` pulses once after byte 512.
  - `dma_done` pulses once after byte 1024, then `active = 0`.
- Read 1 sector, `fifo_full` held high for 10 cycles mid-sector:
  - `sd_rd_stall` goes high, and no word is lost or duplicated.
  - Word count is 256.
- Write 1 sector, FIFO preloaded with 256 words (0xA55A):
  - SD sees 512 bytes alternating 0xA5, 0x5A.
  - `dma_done` pulses once, and `fifo_rd` pulses exactly 256 times.
- `start` with `sector_count = 0`: `dma_done` pulses the next cycle, and `active` stays 0.
- Reply burst of 9 words with `reply_req` held in IDLE:
  - 9 `fifo_wr` equal 9 `reply_ack`, with data matching.
  - `reply_req` during READ gets no ack until IDLE.
- Reset asserted at byte 300 of a read: all outputs are 0 next cycle, and a new `start` reads 1 sector correctly.

Source files
------------

// File: rtl/acsi_dma_bridge.sv
`default_nettype none
// ============================================================================
// Module   : acsi_dma_bridge
// Brief    : Packs SD read bytes into big-endian DMA FIFO words, unpacks FIFO
//            words into SD write bytes, tracks sectors and forwards ACSI
//            reply words to the FIFO while idle.
// Revision : 1.0 - initial release
// ============================================================================
module acsi_dma_bridge #(
    parameter int SECTOR_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic [7:0]  sector_count,
    input  logic [7:0]  sd_rd_data,
    input  logic        sd_rd_strobe,
    output logic        sd_rd_stall,
    output logic [7:0]  sd_wr_data,
    output logic        sd_wr_valid,
    input  logic        sd_wr_ready,
    output logic [15:0] fifo_wdata,
    output logic        fifo_wr,
    input  logic        fifo_full,
    input  logic [15:0] fifo_rdata,
    output logic        fifo_rd,
    input  logic        fifo_empty,
    input  logic [15:0] reply_data,
    input  logic        reply_req,
    output logic        reply_ack,
    output logic        data_next,
    output logic        dma_done,
    output logic        active,
    output logic [7:0]  sectors_left
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [9:0] c_SECTOR_END = 10'(SECTOR_BYTES);

    state_t      r_state;
    state_t      w_state_next;
    logic [8:0]  r_byte_cnt;
    logic [7:0]  r_hi_byte;
    logic [15:0] r_hold;
    logic        r_hold_valid;
    logic        r_rd_pending;
    logic        r_draining;
    logic        r_data_next;
    logic        r_dma_done;
    logic [7:0]  r_sectors_left;

    logic        w_run;
    logic        w_in_idle;
    logic        w_in_read;
    logic        w_in_write;
    logic        w_rd_fifo_wr;
    logic        w_rd_stall;
    logic        w_rd_accept;
    logic        w_wr_valid;
    logic        w_wr_hs;
    logic        w_fifo_rd;
    logic        w_reply_ack;
    logic        w_byte_step;
    logic [9:0]  w_cnt_inc;
    logic        w_sector_end;
    logic [7:0]  w_left_dec;
    logic        w_last_sector;
    logic        w_start_go;
    logic        w_start_zero;
    logic        w_read_finish;

    // Combinational outputs are gated by reset so an abort is silent at once.
    assign w_run         = !reset;
    assign w_in_idle     = (r_state == S_IDLE);
    assign w_in_read     = (r_state == S_READ);
    assign w_in_write    = (r_state == S_WRITE);

    assign w_rd_fifo_wr  = w_run && w_in_read && r_hold_valid && !fifo_full;
    assign w_rd_stall    = w_run && w_in_read && r_hold_valid && fifo_full;
    assign w_rd_accept   = w_run && w_in_read && !r_draining && sd_rd_strobe && !w_rd_stall;

    assign w_wr_valid    = w_run && w_in_write && r_hold_valid;
    assign w_wr_hs       = w_wr_valid && sd_wr_ready;
    assign w_fifo_rd     = w_run && w_in_write && !r_hold_valid && !r_rd_pending && !fifo_empty;

    assign w_reply_ack   = w_run && w_in_idle && reply_req && !fifo_full && !start;

    assign w_byte_step   = w_rd_accept || w_wr_hs;
    assign w_cnt_inc     = {1'b0, r_byte_cnt} + 10'd1;
    assign w_sector_end  = w_byte_step && (w_cnt_inc == c_SECTOR_END);
    assign w_left_dec    = (r_sectors_left != 8'd0) ? (r_sectors_left - 8'd1) : 8'd0;
    assign w_last_sector = (w_left_dec == 8'd0);

    assign w_start_go    = w_in_idle && start && (sector_count != 8'd0);
    assign w_start_zero  = w_in_idle && start && (sector_count == 8'd0);
    // Last read sector ends only once the final packed word leaves the holding register.
    assign w_read_finish = r_draining && w_rd_fifo_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fifo_wr      = 1'b0;
        fifo_wdata   = 16'h0000;
        fifo_rd      = w_fifo_rd;
        reply_ack    = w_reply_ack;
        sd_rd_stall  = w_rd_stall;
        sd_wr_valid  = w_wr_valid;
        sd_wr_data   = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (w_start_go) begin
                    w_state_next = dir ? S_WRITE : S_READ;
                end
                if (w_reply_ack) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = reply_data;
                end
            end
            S_READ: begin
                if (w_read_finish) begin
                    w_state_next = S_IDLE;
                end
                if (w_rd_fifo_wr) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = r_hold;
                end
            end
            S_WRITE: begin
                if (w_sector_end && w_last_sector) begin
                    w_state_next = S_IDLE;
                end
                if (w_wr_valid) begin
                    sd_wr_data = r_byte_cnt[0] ? r_hold[7:0] : r_hold[15:8];
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt     <= 9'd0;
            r_hi_byte      <= 8'h00;
            r_hold         <= 16'h0000;
            r_hold_valid   <= 1'b0;
            r_rd_pending   <= 1'b0;
            r_draining     <= 1'b0;
            r_data_next    <= 1'b0;
            r_dma_done     <= 1'b0;
            r_sectors_left <= 8'd0;
        end else begin
            r_data_next <= 1'b0;
            r_dma_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_zero) begin
                        r_dma_done <= 1'b1;
                    end
                    if (w_start_go) begin
                        r_sectors_left <= sector_count;
                        r_byte_cnt     <= 9'd0;
                        r_hold_valid   <= 1'b0;
                        r_rd_pending   <= 1'b0;
                        r_draining     <= 1'b0;
                    end
                end
                S_READ: begin
                    if (w_rd_accept) begin
                        if (!r_byte_cnt[0]) begin
                            r_hi_byte <= sd_rd_data;
                        end else begin
                            r_hold <= {r_hi_byte, sd_rd_data};
                        end
                    end
                    // A fresh word may refill the register in the cycle it drains.
                    if (w_rd_accept && r_byte_cnt[0]) begin
                        r_hold_valid <= 1'b1;
                    end else if (w_rd_fifo_wr) begin
                        r_hold_valid <= 1'b0;
                    end
                    if (w_read_finish) begin
                        r_dma_done <= 1'b1;
                        r_draining <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_fifo_rd) begin
                        r_rd_pending <= 1'b1;
                    end
                    if (r_rd_pending) begin
                        r_hold       <= fifo_rdata;
                        r_hold_valid <= 1'b1;
                        r_rd_pending <= 1'b0;
                    end else if (w_wr_hs && r_byte_cnt[0]) begin
                        r_hold_valid <= 1'b0;
                    end
                end
                default: begin
                    r_hold_valid <= 1'b0;
                end
            endcase

            if (w_byte_step) begin
                if (w_sector_end) begin
                    r_byte_cnt     <= 9'd0;
                    r_sectors_left <= w_left_dec;
                    if (!w_last_sector) begin
                        r_data_next <= 1'b1;
                    end else if (w_in_write) begin
                        r_dma_done <= 1'b1;
                    end else begin
                        r_draining <= 1'b1;
                    end
                end else begin
                    r_byte_cnt <= w_cnt_inc[8:0];
                end
            end
        end
    end

    assign data_next    = r_data_next;
    assign dma_done     = r_dma_done;
    assign active       = !w_in_idle;
    assign sectors_left = r_sectors_left;

endmodule
`default_nettype wire

// File: tb/tb_acsi_dma_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_acsi_dma_bridge
// Brief    : Scoreboard bench for acsi_dma_bridge read, write, reply and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acsi_dma_bridge;

    localparam int SB    = 512;
    localparam int NEVER = 1000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        dir;
    logic [7:0]  sector_count;
    logic [7:0]  sd_rd_data;
    logic        sd_rd_strobe;
    logic        sd_rd_stall;
    logic [7:0]  sd_wr_data;
    logic        sd_wr_valid;
    logic        sd_wr_ready;
    logic [15:0] fifo_wdata;
    logic        fifo_wr;
    logic        fifo_full;
    logic [15:0] fifo_rdata;
    logic        fifo_rd;
    logic        fifo_empty;
    logic [15:0] reply_data;
    logic        reply_req;
    logic        reply_ack;
    logic        data_next;
    logic        dma_done;
    logic        active;
    logic [7:0]  sectors_left;

    int n_cmp = 0;
    int n_bad = 0;

    acsi_dma_bridge #(.SECTOR_BYTES(SB)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir),
        .sector_count(sector_count), .sd_rd_data(sd_rd_data),
        .sd_rd_strobe(sd_rd_strobe), .sd_rd_stall(sd_rd_stall),
        .sd_wr_data(sd_wr_data), .sd_wr_valid(sd_wr_valid),
        .sd_wr_ready(sd_wr_ready), .fifo_wdata(fifo_wdata),
        .fifo_wr(fifo_wr), .fifo_full(fifo_full), .fifo_rdata(fifo_rdata),
        .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .reply_data(reply_data),
        .reply_req(reply_req), .reply_ack(reply_ack), .data_next(data_next),
        .dma_done(dma_done), .active(active), .sectors_left(sectors_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start = 0; dir = 0; sector_count = 8'd0;
        sd_rd_data = 8'd0; sd_rd_strobe = 0; sd_wr_ready = 0;
        fifo_full = 0; fifo_rdata = 16'h0; fifo_empty = 1;
        reply_data = 16'h0; reply_req = 0;
    endtask

    // Streams bytes 0x00.. of nsec sectors and scoreboards every FIFO word.
    task automatic run_read(input int nsec, input int full_at, input int full_len,
                            input int abort_at, input bit hold_reply,
                            output int words, output bit stall_seen,
                            output logic [15:0] w0, output logic [15:0] w1);
        logic [15:0] exp_q[$];
        logic [15:0] e;
        logic [7:0]  hi;
        int total, sent, it, dn_cnt, dd_cnt, dn_exp_it, dn_it, dd_it, last_wr_it;
        bit done;
        total = nsec * SB; sent = 0; it = 0; dn_cnt = 0; dd_cnt = 0;
        dn_exp_it = -1; dn_it = -1; dd_it = -1; last_wr_it = -1; done = 0;
        words = 0; stall_seen = 0; w0 = 16'hxxxx; w1 = 16'hxxxx; hi = 8'h00;
        tick();
        start = 1; dir = 0; sector_count = nsec[7:0]; reply_req = hold_reply;
        @(negedge clk);
        n_cmp++;
        if (reply_ack !== 1'b0) begin
            n_bad++; $display("FAIL start_priority: reply_ack=%b required 0", reply_ack);
        end
        tick();
        start = 0;
        while (!done && it < total * 2 + 200 && !(abort_at >= 0 && sent >= abort_at)) begin
            fifo_full = (it >= full_at && it < full_at + full_len);
            #1;
            if (sd_rd_stall) stall_seen = 1;
            if (sent < total && !sd_rd_stall) begin
                sd_rd_strobe = 1;
                sd_rd_data = sent[7:0];
                if (sent % 2 == 0) hi = sent[7:0];
                else exp_q.push_back({hi, sent[7:0]});
                sent++;
                if (sent == SB && nsec > 1) dn_exp_it = it + 1;
            end else begin
                sd_rd_strobe = 0;
            end
            @(negedge clk);
            if (fifo_wr && !reply_ack) begin
                if (words == 0) w0 = fifo_wdata;
                if (words == 1) w1 = fifo_wdata;
                words++;
                last_wr_it = it;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL read_word: extra word %h, none expected", fifo_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_wdata !== e) begin
                        n_bad++; $display("FAIL read_word: got %h expected %h", fifo_wdata, e);
                    end
                end
            end
            if (hold_reply && active) begin
                n_cmp++;
                if (reply_ack !== 1'b0) begin
                    n_bad++; $display("FAIL reply_in_read: reply_ack=%b required 0", reply_ack);
                end
            end
            if (data_next) begin dn_cnt++; if (dn_it < 0) dn_it = it; end
            if (dma_done) begin dd_cnt++; dd_it = it; done = 1; end
            it++;
            tick();
        end
        sd_rd_strobe = 0; fifo_full = 0;
        if (abort_at >= 0) return;
        n_cmp++;
        if (dd_cnt !== 1) begin n_bad++; $display("FAIL read_done_count: got %0d required 1", dd_cnt); end
        n_cmp++;
        if (dn_cnt !== nsec - 1) begin n_bad++; $display("FAIL read_next_count: got %0d required %0d", dn_cnt, nsec - 1); end
        if (nsec > 1) begin
            n_cmp++;
            if (dn_it !== dn_exp_it) begin n_bad++; $display("FAIL read_next_timing: cycle %0d required %0d", dn_it, dn_exp_it); end
        end
        n_cmp++;
        if (dd_it !== last_wr_it + 1) begin n_bad++; $display("FAIL read_done_timing: cycle %0d required %0d", dd_it, last_wr_it + 1); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL read_lost: %0d words missing, required 0", exp_q.size()); end
        n_cmp++;
        if (words !== nsec * 256) begin n_bad++; $display("FAIL read_words: got %0d required %0d", words, nsec * 256); end
        @(negedge clk);
        n_cmp++;
        if (active !== 1'b0) begin n_bad++; $display("FAIL read_active_after: got %b required 0", active); end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({fifo_wr, fifo_rd, sd_rd_stall, sd_wr_valid, reply_ack, data_next, dma_done, active} !== 8'h00) begin
            n_bad++; $display("FAIL reset_flags: got %b required 00000000",
                {fifo_wr, fifo_rd, sd_rd_stall, sd_wr_valid, reply_ack, data_next, dma_done, active});
        end
        tick();
        reset = 0;
        @(negedge clk);
        n_cmp++;
        if (fifo_wdata !== 16'h0 || sd_wr_data !== 8'h0) begin
            n_bad++; $display("FAIL reset_data: fifo_wdata=%h sd_wr_data=%h required 0", fifo_wdata, sd_wr_data);
        end
        n_cmp++;
        if (sectors_left !== 8'd0 || active !== 1'b0) begin
            n_bad++; $display("FAIL reset_state: sectors_left=%0d active=%b required 0", sectors_left, active);
        end
    endtask

    task automatic test_read_two_sectors();
        int words; bit st; logic [15:0] w0, w1;
        run_read(2, NEVER, 0, -1, 0, words, st, w0, w1);
        n_cmp++;
        if (w0 !== 16'h0001) begin n_bad++; $display("FAIL read_first_word: got %h required 0001", w0); end
        n_cmp++;
        if (w1 !== 16'h0203) begin n_bad++; $display("FAIL read_second_word: got %h required 0203", w1); end
    endtask

    task automatic test_read_backpressure();
        int words; bit st; logic [15:0] w0, w1;
        run_read(1, 100, 10, -1, 0, words, st, w0, w1);
        n_cmp++;
        if (st !== 1'b1) begin n_bad++; $display("FAIL stall_seen: got %b required 1", st); end
    endtask

    task automatic test_write_sector();
        logic [15:0] src_q[$];
        logic [7:0]  exp_b[$];
        logic [7:0]  e;
        int it, rd_cnt, bytes, dn, dd, dd_it, last_hs, first_rd, first_valid;
        bit done, rd_seen;
        it = 0; rd_cnt = 0; bytes = 0; dn = 0; dd = 0; dd_it = -1; last_hs = -1;
        first_rd = -1; first_valid = -1; done = 0; rd_seen = 0;
        for (int i = 0; i < 256; i++) begin
            src_q.push_back(16'hA55A);
            exp_b.push_back(8'hA5);
            exp_b.push_back(8'h5A);
        end
        tick();
        fifo_empty = 0; start = 1; dir = 1; sector_count = 8'd1;
        @(negedge clk);
        tick();
        start = 0;
        while (!done && it < 4000) begin
            if (rd_seen) begin fifo_rdata = src_q.pop_front(); rd_seen = 0; end
            fifo_empty = (src_q.size() == 0);
            sd_wr_ready = (it % 3 != 2);
            @(negedge clk);
            if (fifo_rd) begin
                rd_cnt++; rd_seen = 1;
                if (first_rd < 0) first_rd = it;
            end
            if (sd_wr_valid && first_valid < 0) first_valid = it;
            if (sd_wr_valid && sd_wr_ready) begin
                bytes++; last_hs = it;
                n_cmp++;
                if (exp_b.size() == 0) begin
                    n_bad++; $display("FAIL write_byte: extra byte %h, none expected", sd_wr_data);
                end else begin
                    e = exp_b.pop_front();
                    if (sd_wr_data !== e) begin
                        n_bad++; $display("FAIL write_byte: got %h expected %h", sd_wr_data, e);
                    end
                end
            end
            if (data_next) dn++;
            if (dma_done) begin dd++; dd_it = it; done = 1; end
            it++;
            tick();
        end
        sd_wr_ready = 0; fifo_empty = 1;
        n_cmp++;
        if (first_valid !== first_rd + 2) begin n_bad++; $display("FAIL write_latency: valid at %0d required %0d", first_valid, first_rd + 2); end
        n_cmp++;
        if (rd_cnt !== 256) begin n_bad++; $display("FAIL write_fifo_rd: got %0d required 256", rd_cnt); end
        n_cmp++;
        if (bytes !== 512) begin n_bad++; $display("FAIL write_bytes: got %0d required 512", bytes); end
        n_cmp++;
        if (dd !== 1 || dn !== 0) begin n_bad++; $display("FAIL write_pulses: dma_done=%0d data_next=%0d required 1/0", dd, dn); end
        n_cmp++;
        if (dd_it !== last_hs + 1) begin n_bad++; $display("FAIL write_done_timing: cycle %0d required %0d", dd_it, last_hs + 1); end
        @(negedge clk);
        n_cmp++;
        if (active !== 1'b0) begin n_bad++; $display("FAIL write_active_after: got %b required 0", active); end
    endtask

    task automatic test_zero_count();
        tick();
        start = 1; dir = 0; sector_count = 8'd0;
        @(negedge clk);
        tick();
        start = 0;
        @(negedge clk);
        n_cmp++;
        if (dma_done !== 1'b1 || active !== 1'b0) begin
            n_bad++; $display("FAIL zero_count_done: dma_done=%b active=%b required 1/0", dma_done, active);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dma_done !== 1'b0 || active !== 1'b0) begin
            n_bad++; $display("FAIL zero_count_pulse: dma_done=%b active=%b required 0/0", dma_done, active);
        end
    endtask

    task automatic test_reply_burst();
        logic [15:0] rq[$];
        int acked, it;
        acked = 0; it = 0;
        for (int i = 0; i < 9; i++) rq.push_back(16'hC000 + 16'(i * 16'h0111));
        tick();
        fifo_full = 1; reply_req = 1; reply_data = rq[0];
        @(negedge clk);
        n_cmp++;
        if (reply_ack !== 1'b0 || fifo_wr !== 1'b0) begin
            n_bad++; $display("FAIL reply_full: ack=%b wr=%b required 0/0", reply_ack, fifo_wr);
        end
        tick();
        fifo_full = 0;
        while (acked < 9 && it < 30) begin
            @(negedge clk);
            n_cmp++;
            if (reply_ack !== fifo_wr) begin
                n_bad++; $display("FAIL reply_ack_wr: ack=%b wr=%b required equal", reply_ack, fifo_wr);
            end
            if (reply_ack) begin
                n_cmp++;
                if (fifo_wdata !== rq[0]) begin
                    n_bad++; $display("FAIL reply_data: got %h expected %h", fifo_wdata, rq[0]);
                end
                void'(rq.pop_front());
                acked++;
            end
            it++;
            tick();
            if (rq.size() > 0) reply_data = rq[0];
            else reply_req = 0;
        end
        n_cmp++;
        if (acked !== 9 || it !== 9) begin
            n_bad++; $display("FAIL reply_burst: %0d acks in %0d cycles required 9 in 9", acked, it);
        end
    endtask

    task automatic test_reply_during_read();
        int words; bit st; logic [15:0] w0, w1;
        reply_data = 16'hBEEF;
        run_read(1, NEVER, 0, -1, 1, words, st, w0, w1);
        n_cmp++;
        if (reply_ack !== 1'b1 || fifo_wdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL reply_after_read: ack=%b data=%h required 1/beef", reply_ack, fifo_wdata);
        end
        tick();
        reply_req = 0;
    endtask

    task automatic test_reset_abort();
        int words; bit st; logic [15:0] w0, w1;
        int wr_seen;
        wr_seen = 0;
        run_read(1, NEVER, 0, 300, 0, words, st, w0, w1);
        reset = 1;
        @(negedge clk);
        tick();
        reset = 0;
        @(negedge clk);
        n_cmp++;
        if ({fifo_wr, fifo_rd, sd_rd_stall, sd_wr_valid, reply_ack, data_next, dma_done, active} !== 8'h00
            || sectors_left !== 8'd0) begin
            n_bad++; $display("FAIL abort_outputs: flags=%b sectors_left=%0d required 0",
                {fifo_wr, fifo_rd, sd_rd_stall, sd_wr_valid, reply_ack, data_next, dma_done, active}, sectors_left);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            if (fifo_wr || dma_done || data_next) wr_seen++;
        end
        n_cmp++;
        if (wr_seen !== 0) begin n_bad++; $display("FAIL abort_quiet: %0d active cycles required 0", wr_seen); end
        run_read(1, NEVER, 0, -1, 0, words, st, w0, w1);
        n_cmp++;
        if (w0 !== 16'h0001) begin n_bad++; $display("FAIL abort_restart_word: got %h required 0001", w0); end
    endtask

    initial begin
        test_reset();
        test_read_two_sectors();
        test_read_backpressure();
        test_write_sector();
        test_zero_count();
        test_reply_burst();
        test_reply_during_read();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
